// File: rtl/ctrl_decode_pipe.sv
// Pipelined control decoder: ID-stage decode registered into the ID/EX control register,
// with stall hold, flush bubbles, sticky error and a halt-drain FSM. Optional counters: CTRL_PERF_CNT_EN.
module ctrl_decode_pipe #(
  parameter int DRAIN_DEPTH = 3,
  parameter int ERR_HALT    = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       opcode,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             jump,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             zero_ext,
  output logic             i1_fmt,
  output logic             halt,
  output logic             err,
  output logic [4:0]       alu_op,
  output logic             fetch_hold,
  output logic             halt_done,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  output logic             err_sticky
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       mem_to_reg;
    logic       reg_write;
    logic       zero_ext;
    logic       i1_fmt;
    logic       halt;
    logic       err;
    logic [4:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam ctrl_t      BUBBLE = '{alu_op: 5'b00001, default: 1'b0};
  localparam logic [3:0] DEPTH  = 4'(DRAIN_DEPTH);

  function automatic ctrl_t decode(input logic [4:0] op);
    ctrl_t c;
    c        = '{default: 1'b0};
    c.alu_op = op;
    case (op)
      5'b00000: c.halt = 1'b1;
      5'b00001, 5'b00010, 5'b00011: ;
      5'b01000, 5'b01001,
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.i1_fmt    = 1'b1;
      end
      5'b01010, 5'b01011: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.i1_fmt    = 1'b1;
        c.zero_ext  = 1'b1;
      end
      5'b10000: begin
        c.alu_src   = 1'b1;
        c.i1_fmt    = 1'b1;
        c.mem_write = 1'b1;
      end
      5'b10001: begin
        c.alu_src    = 1'b1;
        c.i1_fmt     = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      5'b10011: begin
        c.alu_src   = 1'b1;
        c.i1_fmt    = 1'b1;
        c.mem_write = 1'b1;
        c.reg_write = 1'b1;
      end
      5'b11001, 5'b11010, 5'b11011, 5'b11100,
      5'b11101, 5'b11110, 5'b11111: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
        c.alu_src = 1'b1;
        c.branch  = 1'b1;
      end
      5'b11000: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      5'b10010: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.zero_ext  = 1'b1;
      end
      5'b00100: c.jump = 1'b1;
      5'b00101: begin
        c.jump    = 1'b1;
        c.alu_src = 1'b1;
      end
      5'b00110: begin
        c.jump      = 1'b1;
        c.reg_write = 1'b1;
      end
      5'b00111: begin
        c.jump      = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: begin
        c        = '{default: 1'b0};
        c.alu_op = op;
        c.err    = 1'b1;
      end
    endcase
    return c;
  endfunction

  state_t     state, state_nx;
  logic [3:0] dcnt, dcnt_nx;
  ctrl_t      dec, ex_ctrl;
  logic       running, load, bubble_load, enter_drain;
  logic       ex_valid_q, halt_done_q, err_sticky_q;

  // ID-stage decode and load qualification
  always_comb begin
    dec         = decode(id_valid ? opcode : 5'b00001);
    running     = (state == RUN);
    bubble_load = !running || flush;
    load        = running && !flush && !stall;
    enter_drain = load && (dec.halt || ((ERR_HALT != 0) && dec.err));
  end

  // Halt-drain next state and drain counter
  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    case (state)
      RUN: begin
        if (enter_drain) begin
          state_nx = DRAIN;
          dcnt_nx  = DEPTH;
        end else begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        dcnt_nx = dcnt - 4'd1;
        // <=1 so a mis-set depth of 0 still terminates
        if (dcnt <= 4'd1) begin
          state_nx = HALTED;
        end else begin
          state_nx = DRAIN;
        end
      end
      HALTED:  state_nx = HALTED;
      default: begin
        state_nx = RUN;
        dcnt_nx  = 4'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      dcnt  <= 4'd0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // ID/EX control register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl    <= BUBBLE;
      ex_valid_q <= 1'b0;
    end else if (bubble_load) begin
      ex_ctrl    <= BUBBLE;
      ex_valid_q <= 1'b0;
    end else if (stall) begin
      ex_ctrl    <= ex_ctrl;
      ex_valid_q <= ex_valid_q;
    end else begin
      ex_ctrl    <= dec;
      ex_valid_q <= id_valid;
    end
  end

  // Sticky status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_done_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (state_nx == HALTED) begin
        halt_done_q <= 1'b1;
      end
      if (load && dec.err) begin
        err_sticky_q <= 1'b1;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] instr_q, bubble_q;

  // Saturating performance counters; stall holds count as neither
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (load && id_valid && (instr_q != CNT_MAX)) begin
        instr_q <= instr_q + 1'b1;
      end
      if (bubble_load && (bubble_q != CNT_MAX)) begin
        bubble_q <= bubble_q + 1'b1;
      end
    end
  end

  assign instr_cnt  = instr_q;
  assign bubble_cnt = bubble_q;
`endif

  assign ex_valid   = ex_valid_q;
  assign reg_dst    = ex_ctrl.reg_dst;
  assign alu_src    = ex_ctrl.alu_src;
  assign branch     = ex_ctrl.branch;
  assign mem_read   = ex_ctrl.mem_read;
  assign mem_write  = ex_ctrl.mem_write;
  assign jump       = ex_ctrl.jump;
  assign mem_to_reg = ex_ctrl.mem_to_reg;
  assign reg_write  = ex_ctrl.reg_write;
  assign zero_ext   = ex_ctrl.zero_ext;
  assign i1_fmt     = ex_ctrl.i1_fmt;
  assign halt       = ex_ctrl.halt;
  assign err        = ex_ctrl.err;
  assign alu_op     = ex_ctrl.alu_op;
  assign fetch_hold = (state == DRAIN) || (state == HALTED);
  assign halt_done  = halt_done_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe: directed steps push hand-computed expected
// output words; a monitor pops and compares one word per cycle after each rising edge.
module tb_ctrl_decode_pipe;

  localparam logic [20:0] M_V   = 21'h100000;
  localparam logic [20:0] M_RD  = 21'h080000;
  localparam logic [20:0] M_AS  = 21'h040000;
  localparam logic [20:0] M_BR  = 21'h020000;
  localparam logic [20:0] M_MR  = 21'h010000;
  localparam logic [20:0] M_MW  = 21'h008000;
  localparam logic [20:0] M_J   = 21'h004000;
  localparam logic [20:0] M_M2R = 21'h002000;
  localparam logic [20:0] M_RW  = 21'h001000;
  localparam logic [20:0] M_ZX  = 21'h000800;
  localparam logic [20:0] M_I1  = 21'h000400;
  localparam logic [20:0] M_H   = 21'h000200;
  localparam logic [20:0] M_FH  = 21'h000004;
  localparam logic [20:0] M_HD  = 21'h000002;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic ex_valid, reg_dst, alu_src, branch, mem_read, mem_write, jump;
  logic mem_to_reg, reg_write, zero_ext, i1_fmt, halt, err;
  logic [4:0] alu_op;
  logic fetch_hold, halt_done, err_sticky;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] instr_cnt, bubble_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic [20:0] expq[$];
  string       nameq[$];
  logic [20:0] tab[32];

  ctrl_decode_pipe #(.DRAIN_DEPTH(3), .ERR_HALT(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .reg_dst(reg_dst),
    .alu_src(alu_src), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .jump(jump), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .zero_ext(zero_ext), .i1_fmt(i1_fmt),
    .halt(halt), .err(err), .alu_op(alu_op), .fetch_hold(fetch_hold),
    .halt_done(halt_done),
`ifdef CTRL_PERF_CNT_EN
    .instr_cnt(instr_cnt), .bubble_cnt(bubble_cnt),
`endif
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] op_f(input logic [4:0] o);
    return {13'd0, o, 3'd0};
  endfunction

  localparam logic [20:0] BUB = {13'd0, 5'b00001, 3'd0};

  task automatic step(input logic r, input logic v, input logic [4:0] o,
                      input logic s, input logic f, input logic [20:0] e,
                      input string nm);
    @(negedge clk);
    rst = r; id_valid = v; opcode = o; stall = s; flush = f;
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  // Monitor: one expected word per cycle, checked 1 time unit after the edge
  initial begin
    logic [20:0] obs, e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n = nameq.pop_front();
        obs = {ex_valid, reg_dst, alu_src, branch, mem_read, mem_write, jump,
               mem_to_reg, reg_write, zero_ext, i1_fmt, halt, err, alu_op,
               fetch_hold, halt_done, err_sticky};
        checks++;
        if (obs === e) passes++;
        else $display("FAIL %s: got %h required %h", n, obs, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Hand-derived control flags per opcode (ex_valid and alu_op added per step)
    tab[0] = M_H;
    tab[1] = 21'd0; tab[2] = 21'd0; tab[3] = 21'd0;
    tab[4] = M_J; tab[5] = M_J | M_AS; tab[6] = M_J | M_RW; tab[7] = M_J | M_RW | M_AS;
    tab[8] = M_AS | M_RW | M_I1; tab[9] = M_AS | M_RW | M_I1;
    tab[10] = M_AS | M_RW | M_I1 | M_ZX; tab[11] = M_AS | M_RW | M_I1 | M_ZX;
    for (int i = 12; i < 16; i++) tab[i] = M_AS | M_BR;
    tab[16] = M_AS | M_I1 | M_MW;
    tab[17] = M_AS | M_I1 | M_MR | M_M2R | M_RW;
    tab[18] = M_AS | M_RW | M_ZX;
    tab[19] = M_AS | M_I1 | M_MW | M_RW;
    for (int i = 20; i < 24; i++) tab[i] = M_AS | M_RW | M_I1;
    tab[24] = M_AS | M_RW;
    for (int i = 25; i < 32; i++) tab[i] = M_RD | M_RW;

    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, BUB, "reset");
    step(1'b0, 1'b1, 5'b10001, 1'b0, 1'b0,
         M_V | M_AS | M_MR | M_M2R | M_RW | M_I1 | op_f(5'b10001), "load_10001");
    step(1'b0, 1'b1, 5'b11011, 1'b0, 1'b0, M_V | M_RD | M_RW | op_f(5'b11011), "load_11011");
    step(1'b0, 1'b1, 5'b01000, 1'b1, 1'b0, M_V | M_RD | M_RW | op_f(5'b11011), "stall_hold1");
    step(1'b0, 1'b1, 5'b01000, 1'b1, 1'b0, M_V | M_RD | M_RW | op_f(5'b11011), "stall_hold2");
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b0, M_V | M_AS | M_RW | M_I1 | op_f(5'b01000), "after_stall");
    step(1'b0, 1'b1, 5'b00110, 1'b1, 1'b1, BUB, "flush_beats_stall");
    step(1'b0, 1'b0, 5'b00110, 1'b0, 1'b0, BUB, "invalid_is_nop");
    step(1'b0, 1'b1, 5'b00110, 1'b0, 1'b0, M_V | M_J | M_RW | op_f(5'b00110), "load_00110");
    step(1'b0, 1'b1, 5'b00111, 1'b0, 1'b1, BUB, "flush_bubble");
    step(1'b0, 1'b1, 5'b00111, 1'b1, 1'b0, BUB, "stall_holds_bubble");

    // Every 5-bit opcode is a table entry, so err and err_sticky stay 0 throughout
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b1, 5'(i), 1'b0, 1'b0, M_V | tab[i] | op_f(5'(i)), $sformatf("decode_%0d", i));
    end

    // Halt drain with DRAIN_DEPTH=3; stall/flush during drain ignored
    step(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, M_V | M_H | op_f(5'd0) | M_FH, "halt_load");
    step(1'b0, 1'b1, 5'b10001, 1'b1, 1'b0, BUB | M_FH, "drain1_stall");
    step(1'b0, 1'b1, 5'b10001, 1'b0, 1'b1, BUB | M_FH, "drain2_flush");
    step(1'b0, 1'b1, 5'b10001, 1'b0, 1'b0, BUB | M_FH | M_HD, "halt_done");
    step(1'b0, 1'b1, 5'b11011, 1'b0, 1'b0, BUB | M_FH | M_HD, "halted_stays");
    step(1'b1, 1'b1, 5'b11011, 1'b0, 1'b0, BUB, "reset_from_halted");

    // Reset mid-drain, then halt held in ID under stall
    step(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, M_V | M_H | op_f(5'd0) | M_FH, "halt_load2");
    step(1'b0, 1'b1, 5'b00001, 1'b0, 1'b0, BUB | M_FH, "drain_b");
    step(1'b1, 1'b1, 5'b00001, 1'b0, 1'b0, BUB, "reset_mid_drain");
    step(1'b0, 1'b1, 5'b10001, 1'b0, 1'b0,
         M_V | M_AS | M_MR | M_M2R | M_RW | M_I1 | op_f(5'b10001), "run_after_reset");
    step(1'b0, 1'b1, 5'b00000, 1'b1, 1'b0,
         M_V | M_AS | M_MR | M_M2R | M_RW | M_I1 | op_f(5'b10001), "halt_stalled");
    step(1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, M_V | M_H | op_f(5'd0) | M_FH, "halt_after_stall");
    step(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, BUB, "reset_final");

`ifdef CTRL_PERF_CNT_EN
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b0, M_V | tab[8] | op_f(5'd8), "perf_v1");
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b0, M_V | tab[8] | op_f(5'd8), "perf_v2");
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b1, BUB, "perf_f1");
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b0, M_V | tab[8] | op_f(5'd8), "perf_v3");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'b01000, 1'b1, 1'b0, M_V | tab[8] | op_f(5'd8), "perf_stall");
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b0, M_V | tab[8] | op_f(5'd8), "perf_v4");
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b1, BUB, "perf_f2");
    step(1'b0, 1'b1, 5'b01000, 1'b0, 1'b0, M_V | tab[8] | op_f(5'd8), "perf_v5");
    @(negedge clk);
    id_valid = 1'b0;
    stall = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (instr_cnt === 16'd5) passes++;
    else $display("FAIL instr_cnt: got %0d required 5", instr_cnt);
    checks++;
    if (bubble_cnt === 16'd2) passes++;
    else $display("FAIL bubble_cnt: got %0d required 2", bubble_cnt);
`endif

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expq.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending required 0", expq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
